// File: rtl/icache_fetch_resp.sv
// rtl/icache_fetch_resp.sv - direct-mapped multi-word-line I-cache responder for the IF stage
// Zero-latency lookup, one refill engine; other lines keep hitting while a refill is in flight.
module icache_fetch_resp #(
  parameter int WORD_W     = 32,
  parameter int HART_W     = 2,
  parameter int SET_NUM    = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] if_pc,
  input  logic [HART_W-1:0] hart_id,
  input  logic              fetch_en,
  input  logic              inv,
  output logic [WORD_W-1:0] insn,
  output logic              data_rdy,
  output logic              cache_miss,
  output logic [HART_W-1:0] cm_hart_id,
  output logic [WORD_W-1:0] cm_addr,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rd_valid,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              busy
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SET_NUM);
  localparam int TAG_W = WORD_W - IDX_W - OFF_W - 2;
  localparam logic [WORD_W-1:0] OP_NOP = WORD_W'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_mem  [SET_NUM];
  logic [WORD_W-1:0] data_mem [SET_NUM*LINE_WORDS];
  logic [SET_NUM-1:0] valid;

  logic [IDX_W-1:0]  fill_index;
  logic [TAG_W-1:0]  fill_tag;
  logic [OFF_W-1:0]  beat_cnt;
  logic              discard;
  logic [WORD_W-1:0] line_base;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             unused_pc_lsb;
  logic             refill_active, hit, miss, last_beat, start_fill, beat_wr;

  assign pc_off        = if_pc[OFF_W+1:2];
  assign pc_idx        = if_pc[OFF_W+IDX_W+1:OFF_W+2];
  assign pc_tag        = if_pc[WORD_W-1:OFF_W+IDX_W+2];
  assign unused_pc_lsb = ^if_pc[1:0];

  // The line being refilled is never served, even with a matching tag.
  assign refill_active = (state != IDLE);
  assign hit = !reset && fetch_en && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag) &&
               !(refill_active && (pc_idx == fill_index));
  assign miss       = !reset && fetch_en && !hit;
  assign beat_wr    = (state == FILL) && mem_rd_valid;
  assign last_beat  = beat_wr && (beat_cnt == OFF_W'(LINE_WORDS-1));
  assign start_fill = (state == IDLE) && miss && !inv;

  assign insn       = hit ? data_mem[{pc_idx, pc_off}] : OP_NOP;
  assign data_rdy   = hit;
  assign cache_miss = miss;
  assign cm_hart_id = miss ? hart_id : '0;
  assign cm_addr    = miss ? if_pc : '0;
  assign mem_req    = (state == REQ);
  assign mem_addr   = line_base;
  assign busy       = refill_active;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_fill) state_nxt = REQ;
      REQ:     if (mem_ack)    state_nxt = FILL;
      FILL:    if (last_beat)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      fill_index <= '0;
      fill_tag   <= '0;
      line_base  <= '0;
      beat_cnt   <= '0;
      discard    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_fill) begin
        fill_index <= pc_idx;
        fill_tag   <= pc_tag;
        line_base  <= {if_pc[WORD_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
      end
      if ((state == REQ) && mem_ack) beat_cnt <= '0;
      else if (beat_wr)              beat_cnt <= beat_cnt + 1'b1;
      if (refill_active && inv) discard <= 1'b1;
      if (last_beat)            discard <= 1'b0;
      // inv in the final-beat cycle must also leave the line invalid.
      if (inv)                           valid <= '0;
      else if (last_beat && !discard)    valid[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr)   data_mem[{fill_index, beat_cnt}] <= mem_rd_data;
    if (last_beat) tag_mem[fill_index] <= fill_tag;
  end
endmodule

// File: doc/icache_fetch_resp.md
Name: icache_fetch_resp

Overview:
Instruction-side responder for the IF stage of the multi-hart core. It answers each fetch address and hart ID with either an instruction plus `data_rdy`, or a one-cycle `cache_miss` pulse carrying the missing hart and PC. It is a direct-mapped, multi-word-line I-cache with a single refill engine toward instruction memory. Hits from other harts are served while a refill is in flight.

Parameters:
- WORD_W, 32, instruction/address width (`WORD_DATA_W`)
- HART_W, 2, hart ID width (`HART_ID_W`)
- SET_NUM, 64, number of cache lines (power of 2)
- LINE_WORDS, 4, words per line (power of 2, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- if_pc  in  WORD_W  fetch address of the selected hart
- hart_id  in  HART_W  hart issuing this fetch
- fetch_en  in  1  fetch valid this cycle (low when IF is stalled)
- inv  in  1  invalidate all lines (fence.i)
- insn  out  WORD_W  fetched instruction
- data_rdy  out  1  insn valid this cycle
- cache_miss  out  1  one-cycle miss pulse
- cm_hart_id  out  HART_W  hart that missed
- cm_addr  out  WORD_W  PC to refetch (equals if_pc of the missing fetch)
- mem_req  out  1  refill request, held until ack
- mem_addr  out  WORD_W  line-aligned refill address
- mem_ack  in  1  memory accepted the request
- mem_rd_valid  in  1  refill beat valid
- mem_rd_data  in  WORD_W  refill beat data, word 0 first
- busy  out  1  refill in progress (state != IDLE)

Behaviour:
- Address split:
  - word offset = if_pc[log2(LINE_WORDS)+1:2]
  - index = the next log2(SET_NUM) bits
  - tag = the remaining upper bits
  - if_pc[1:0] is ignored.
- Lookup is combinational from the registered tag/valid/data arrays. `insn`, `data_rdy`, `cache_miss`, `cm_*` are valid in the same cycle as `if_pc`, with zero latency.
- hit = fetch_en & valid[index] & (tag match) & !(refill active & index == fill_index).
- data_rdy = hit.
- insn = line word when hit, else `OP_NOP`.
- cache_miss = fetch_en & !hit. When it is asserted: cm_hart_id = hart_id and cm_addr = if_pc. When it is low, cm_hart_id and cm_addr are 0.
- FSM states are IDLE, REQ and FILL.
  - IDLE: a miss with !inv latches fill_index, fill_tag, line base `{if_pc[WORD_W-1:offset_msb+1], 0}` and goes to REQ. The miss pulse is still reported this cycle.
  - REQ: mem_req = 1 and mem_addr = line base, both held stable. On mem_ack go to FILL and clear beat_cnt.
  - FILL: each mem_rd_valid writes mem_rd_data into word beat_cnt and increments beat_cnt. On the beat where beat_cnt == LINE_WORDS-1, write the tag, set valid unless discard, and go to IDLE.
- During REQ/FILL, a miss only pulses cache_miss and never starts a second refill; the hart refetches later. Any access to fill_index, even if its tag matches, is treated as a miss.
- Final fill beat and a fetch to fill_index in the same cycle: the fetch misses. The line is usable from the next cycle.
- inv, one cycle, clears every valid bit at the clock edge.
  - inv in REQ/FILL sets discard. The refill completes its handshake but leaves its line invalid. discard clears on return to IDLE.
  - A fetch in the inv cycle still uses the pre-edge arrays.
  - inv in IDLE together with a miss: no refill is started.
- mem_rd_valid outside FILL is ignored.
- Reset, asynchronous and also mid-refill:
  - all valid bits = 0, state = IDLE, beat_cnt = 0, discard = 0, mem_req = 0, mem_addr = 0, busy = 0.
  - outputs fall to insn = `OP_NOP`, data_rdy = 0 and cache_miss = 0 while reset is held.
  - The tag and data arrays are not reset.
- mem_req and mem_addr come from state registers only, never combinationally from if_pc.

Test Plan:
- Cold miss, then fill and hit:
  - After reset, fetch hart 1 at pc 0x100. Required: cache_miss=1, cm_hart_id=1, cm_addr=0x100, then mem_req=1 with mem_addr=0x100.
  - Ack, then send beats 0xA0..0xA3.
  - Next fetch at 0x104 gives data_rdy=1 and insn=0xA1.
- Hit under miss:
  - Preload the line at 0x200, then hart 0 misses on 0x400 and the refill is in FILL.
  - Hart 2 fetches 0x208: data_rdy=1 with the correct word. No second mem_req is issued.
- Conflict during fill:
  - During the refill of 0x400 (index 0), hart 3 fetches 0x800 (same index, also 0).
  - Required: cache_miss=1, cm_addr=0x800. State, mem_addr and beat_cnt are unchanged.
- Invalidate mid-fill:
  - Pulse inv in FILL after beat 1 and finish the beats.
  - Required: state returns to IDLE, and a fetch of 0x400 misses. A previously valid 0x200 also misses.
- Reset mid-refill:
  - Assert reset asynchronously between clock edges while in REQ.
  - Required: mem_req and busy drop immediately. After release, a fetch of 0x400 misses and restarts a refill.
- Delayed ack:
  - Hold mem_ack low for 5 cycles in REQ.
  - Required: mem_req and mem_addr stay stable, and mem_rd_valid pulses during REQ do not write the arrays.
